// File: rtl/dual_clock_fifo_pkg.sv
// Shared pointer types and Gray-code helpers for the dual-clock FIFO.
package dual_clock_fifo_pkg;

    localparam int unsigned PKG_PTR_W = 6;
    localparam int unsigned ADDR_W    = PKG_PTR_W - 1;

    typedef logic [PKG_PTR_W-1:0] ptr_t;
    typedef logic [ADDR_W-1:0]    addr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix-XOR of all higher Gray bits recovers the binary value.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int unsigned i = 1; i < PKG_PTR_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
module fifo_sync2 #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dual_clock_fifo.sv
// Asynchronous FIFO: words written on w_clk, read on r_clk, Gray pointers
// synchronized across domains with conservative full/empty flags.
module dual_clock_fifo
    import dual_clock_fifo_pkg::*;
#(
    parameter int unsigned BITSIZE       = 8,
    parameter int unsigned MEMSIZE       = 32,
    parameter int unsigned POINTERLENGTH = 6
) (
    input  logic               w_clk,
    input  logic               r_clk,
    input  logic               reset,
    input  logic               w_enable,
    input  logic [BITSIZE-1:0] wdata,
    input  logic               r_enable,
    output logic [BITSIZE-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int unsigned P  = POINTERLENGTH;
    localparam int unsigned AW = P - 1;
    // Full when the write pointer is one lap ahead: top two Gray bits differ.
    localparam logic [P-1:0] FULL_MASK = P'(3) << (P - 2);

    typedef logic [P-1:0] lptr_t;

    function automatic lptr_t to_gray(input lptr_t bin);
        return P'(bin2gray(PKG_PTR_W'(bin)));
    endfunction

    logic [BITSIZE-1:0] mem_q [MEMSIZE];

    logic  write_c;
    lptr_t wbin_q,  wbin_d;
    lptr_t wgray_q, wgray_d;
    lptr_t rgray_wsync;
    logic  full_q,  full_d;

    logic         read_c;
    lptr_t        rbin_q,  rbin_d;
    lptr_t        rgray_q, rgray_d;
    lptr_t        wgray_rsync;
    logic         empty_q, empty_d;
    logic [BITSIZE-1:0] rdata_q;

    // Write side: accept, advance pointer, evaluate full on the next pointer.
    always_comb begin
        write_c = w_enable & ~full_q & ~reset;
        wbin_d  = wbin_q + P'(write_c);
        wgray_d = to_gray(wbin_d);
        full_d  = ((wgray_d ^ rgray_wsync) == FULL_MASK);
    end

    always_ff @(posedge w_clk) begin
        if (reset) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
        end
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge w_clk) begin
        if (write_c) begin
            mem_q[wbin_q[AW-1:0]] <= wdata;
        end
    end

    // Read side: mirror of the write side, empty evaluated on the next pointer.
    always_comb begin
        read_c  = r_enable & ~empty_q & ~reset;
        rbin_d  = rbin_q + P'(read_c);
        rgray_d = to_gray(rbin_d);
        empty_d = (rgray_d == wgray_rsync);
    end

    always_ff @(posedge r_clk) begin
        if (reset) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
            rdata_q <= '0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
            if (read_c) begin
                rdata_q <= mem_q[rbin_q[AW-1:0]];
            end
        end
    end

    fifo_sync2 #(.WIDTH(P)) u_sync_w2r (
        .clk   (r_clk),
        .reset (reset),
        .d_i   (wgray_q),
        .q_o   (wgray_rsync)
    );

    fifo_sync2 #(.WIDTH(P)) u_sync_r2w (
        .clk   (w_clk),
        .reset (reset),
        .d_i   (rgray_q),
        .q_o   (rgray_wsync)
    );

    assign full  = full_q;
    assign empty = empty_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dual_clock_fifo.sv
// Directed and streaming checks for dual_clock_fifo.
module tb_dual_clock_fifo;

    logic       w_clk = 1'b0;
    logic       r_clk = 1'b0;
    logic       reset = 1'b1;
    logic       w_enable = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       r_enable = 1'b0;
    logic [7:0] rdata;
    logic       full;
    logic       empty;

    int w_half = 50;
    int r_half = 70;

    always #(w_half) w_clk = ~w_clk;
    always #(r_half) r_clk = ~r_clk;

    dual_clock_fifo #(
        .BITSIZE       (8),
        .MEMSIZE       (32),
        .POINTERLENGTH (6)
    ) dut (
        .w_clk    (w_clk),
        .r_clk    (r_clk),
        .reset    (reset),
        .w_enable (w_enable),
        .wdata    (wdata),
        .r_enable (r_enable),
        .rdata    (rdata),
        .full     (full),
        .empty    (empty)
    );

    typedef struct {
        logic       w_en;
        logic [7:0] wdata;
        logic       exp_full;
    } wvec_t;

    typedef struct {
        logic       r_en;
        logic [7:0] exp_rdata;
        logic       exp_empty;
    } rvec_t;

    wvec_t fill_tbl[33];
    rvec_t drain_tbl[34];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];
    int         pushed = 0;
    int         popped = 0;
    logic       rd_acc;
    logic [7:0] exp_byte;
    int         cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge w_clk);
        reset    = 1'b1;
        w_enable = 1'b0;
        r_enable = 1'b0;
        repeat (10) @(negedge w_clk);
        reset = 1'b0;
        repeat (4) @(negedge r_clk);
    endtask

    task automatic write_word(input logic [7:0] d);
        @(negedge w_clk);
        w_enable = 1'b1;
        wdata    = d;
        @(posedge w_clk);
        #1;
        w_enable = 1'b0;
    endtask

    task automatic read_word();
        @(negedge r_clk);
        r_enable = 1'b1;
        @(posedge r_clk);
        #1;
        r_enable = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 33; i++) begin
            fill_tbl[i].w_en     = 1'b1;
            fill_tbl[i].wdata    = (i < 32) ? 8'(i) : 8'hAA;
            fill_tbl[i].exp_full = (i >= 31);
        end
        for (int i = 0; i < 34; i++) begin
            drain_tbl[i].r_en      = 1'b1;
            drain_tbl[i].exp_rdata = (i < 32) ? 8'(i) : 8'h1F;
            drain_tbl[i].exp_empty = (i >= 31);
        end

        // Reset with requests asserted: nothing may be accepted.
        reset    = 1'b1;
        w_enable = 1'b1;
        wdata    = 8'h77;
        r_enable = 1'b1;
        repeat (8) @(negedge w_clk);
        check("reset_full", full, 0);
        check("reset_empty", empty, 1);
        check("reset_rdata", rdata, 8'h00);
        reset    = 1'b0;
        w_enable = 1'b0;
        r_enable = 1'b0;
        repeat (6) @(negedge r_clk);
        check("post_reset_empty", empty, 1);
        check("post_reset_full", full, 0);
        check("post_reset_rdata", rdata, 8'h00);

        // Fill: full on the 32nd write, 33rd write dropped.
        for (int i = 0; i < 33; i++) begin
            @(negedge w_clk);
            w_enable = fill_tbl[i].w_en;
            wdata    = fill_tbl[i].wdata;
            @(posedge w_clk);
            #1;
            check($sformatf("fill[%0d].full", i), full, fill_tbl[i].exp_full);
        end
        @(negedge w_clk);
        w_enable = 1'b0;
        repeat (6) @(negedge r_clk);
        check("fill_empty_deasserted", empty, 0);

        // Drain: in-order data, empty on the 32nd read, rdata holds afterwards.
        for (int i = 0; i < 34; i++) begin
            @(negedge r_clk);
            r_enable = drain_tbl[i].r_en;
            @(posedge r_clk);
            #1;
            check($sformatf("drain[%0d].rdata", i), rdata, drain_tbl[i].exp_rdata);
            check($sformatf("drain[%0d].empty", i), empty, drain_tbl[i].exp_empty);
        end
        @(negedge r_clk);
        r_enable = 1'b0;
        repeat (6) @(negedge w_clk);
        check("drain_full_released", full, 0);

        // Wrap: pointers cross the address wrap and the MSB toggle.
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 20; i++) begin
                write_word(8'(8'h40 + rnd * 20 + i));
                check($sformatf("wrap%0d[%0d].full", rnd, i), full, 0);
            end
            repeat (6) @(negedge r_clk);
            for (int i = 0; i < 20; i++) begin
                @(negedge r_clk);
                r_enable = 1'b1;
                @(posedge r_clk);
                #1;
                check($sformatf("wrap%0d[%0d].rdata", rnd, i), rdata, 8'(8'h40 + rnd * 20 + i));
                check($sformatf("wrap%0d[%0d].empty", rnd, i), empty, (i == 19) ? 1 : 0);
            end
            @(negedge r_clk);
            r_enable = 1'b0;
        end

        // Empty release latency after a single write.
        write_word(8'h5A);
        cnt = 0;
        while (empty && cnt < 8) begin
            @(posedge r_clk);
            #1;
            cnt++;
        end
        check("empty_fall_latency", (empty == 1'b0 && cnt <= 4), 1);
        read_word();
        check("single_rdata", rdata, 8'h5A);
        check("single_empty", empty, 1);

        // Full release latency after a single read from a full FIFO.
        for (int i = 0; i < 32; i++) begin
            write_word(8'(8'h80 + i));
        end
        check("refill_full", full, 1);
        repeat (6) @(negedge r_clk);
        read_word();
        check("refill_first_rdata", rdata, 8'h80);
        cnt = 0;
        while (full && cnt < 8) begin
            @(posedge w_clk);
            #1;
            cnt++;
        end
        check("full_fall_latency", (full == 1'b0 && cnt <= 4), 1);

        // Reset mid-operation discards the 31 buffered words.
        apply_reset();
        check("midreset_full", full, 0);
        check("midreset_empty", empty, 1);
        check("midreset_rdata", rdata, 8'h00);
        repeat (6) @(negedge r_clk);
        check("midreset_still_empty", empty, 1);

        // Concurrent streaming on faster, unrelated clocks.
        w_half = 35;
        r_half = 65;
        apply_reset();
        fork
            begin
                for (int cyc = 0; cyc < 30000 && pushed < 1000; cyc++) begin
                    @(negedge w_clk);
                    w_enable = ($urandom_range(0, 9) < 6);
                    wdata    = 8'($urandom);
                    if (w_enable && !full) begin
                        sb.push_back(wdata);
                        pushed++;
                    end
                end
                @(negedge w_clk);
                w_enable = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 40000 && popped < 1000; cyc++) begin
                    @(negedge r_clk);
                    r_enable = ($urandom_range(0, 1) == 1);
                    rd_acc   = r_enable && !empty;
                    @(posedge r_clk);
                    #1;
                    if (rd_acc) begin
                        if (sb.size() == 0) begin
                            check("stream_underflow", 1, 0);
                        end else begin
                            exp_byte = sb.pop_front();
                            check("stream_rdata", rdata, exp_byte);
                        end
                        popped++;
                    end
                end
                @(negedge r_clk);
                r_enable = 1'b0;
            end
        join
        check("stream_pushed", pushed, 1000);
        check("stream_popped", popped, 1000);
        check("stream_sb_empty", sb.size(), 0);
        repeat (6) @(negedge w_clk);
        check("stream_end_empty", empty, 1);
        check("stream_end_full", full, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
